// File: rtl/sd_dat_block_reader.sv
// SD 4-bit DAT single-block receiver with Avalon-MM control/status and
// a 128x32 capture buffer; checks per-line CRC16 and the end bit.
module sd_dat_block_reader #(
   parameter int CLK_DIV       = 4,
   parameter int TIMEOUT_EDGES = 4096,
   parameter int BLOCK_WORDS   = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [3:0]  sd_dat_in,
   output logic        sd_clk,
   output logic        irq
);

   localparam int PW = $clog2(BLOCK_WORDS);
   localparam int NW = PW + 3;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EW = $clog2(TIMEOUT_EDGES + 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_START, DATA, CRC, ENDBIT, DONE
   } state_t;

   state_t state, state_n;

   logic [DW-1:0]       div_cnt;
   logic [EW-1:0]       edge_cnt;
   logic [NW-1:0]       nib_cnt;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       buf_ptr;
   logic [3:0][15:0]    crc;
   logic [3:0]          crc_msb;
   logic [7:0][3:0]     word_acc;
   logic [7:0][3:0]     word_nxt;
   logic [31:0]         mem [BLOCK_WORDS];
   logic                done, crc_err, timeout, end_err, irq_en;
   logic                busy, rise, abort, start_ok, mem_we;
   logic                wr_ctrl, wr_ptrreg, rd_data;
   logic                unused_ok;

   assign unused_ok = ^writedata;

   function automatic logic [15:0] crc16_step(logic [15:0] c, logic b);
      return {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
   endfunction

   assign wr_ctrl   = chipselect && !write_n && (address == 2'd0);
   assign wr_ptrreg = chipselect && !write_n && (address == 2'd2);
   assign rd_data   = chipselect && read && (address == 2'd3);
   assign abort     = wr_ctrl && writedata[1];
   assign start_ok  = wr_ctrl && writedata[0] && !writedata[1]
                      && (state == IDLE || state == DONE);
   assign busy      = (state == WAIT_START) || (state == DATA)
                      || (state == CRC) || (state == ENDBIT);
   assign rise      = busy && !abort && !sd_clk
                      && (div_cnt == DW'(CLK_DIV - 1));
   assign mem_we    = !reset && rise && (state == DATA)
                      && (nib_cnt[2:0] == 3'd7);
   assign irq       = irq_en && (done || crc_err || timeout || end_err);

   always_comb begin
      for (int j = 0; j < 4; j++) crc_msb[j] = crc[j][15];
   end

   // First nibble of each byte lands in the upper half of that byte lane.
   always_comb begin
      word_nxt = word_acc;
      word_nxt[{nib_cnt[2:1], ~nib_cnt[0]}] = sd_dat_in;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE, DONE: if (start_ok) state_n = WAIT_START;
            WAIT_START:
               if (rise) begin
                  if (sd_dat_in == 4'h0)
                     state_n = DATA;
                  else if (edge_cnt == EW'(TIMEOUT_EDGES - 1))
                     state_n = DONE;
               end
            DATA:   if (rise && (&nib_cnt)) state_n = CRC;
            CRC:    if (rise && (nib_cnt[3:0] == 4'hF)) state_n = ENDBIT;
            ENDBIT: if (rise) state_n = DONE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !busy || abort) begin
         div_cnt <= '0;
         sd_clk  <= 1'b0;
      end else if (div_cnt == DW'(CLK_DIV - 1)) begin
         div_cnt <= '0;
         sd_clk  <= ~sd_clk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done     <= 1'b0;
         crc_err  <= 1'b0;
         timeout  <= 1'b0;
         end_err  <= 1'b0;
         edge_cnt <= '0;
         nib_cnt  <= '0;
         wr_ptr   <= '0;
         crc      <= '0;
         word_acc <= '0;
      end else if (start_ok) begin
         done     <= 1'b0;
         crc_err  <= 1'b0;
         timeout  <= 1'b0;
         end_err  <= 1'b0;
         edge_cnt <= '0;
         nib_cnt  <= '0;
         wr_ptr   <= '0;
         crc      <= '0;
      end else if (rise) begin
         unique case (state)
            WAIT_START:
               if (sd_dat_in != 4'h0) begin
                  if (edge_cnt == EW'(TIMEOUT_EDGES - 1)) begin
                     timeout <= 1'b1;
                     done    <= 1'b1;
                  end else begin
                     edge_cnt <= edge_cnt + 1'b1;
                  end
               end
            DATA: begin
               for (int j = 0; j < 4; j++)
                  crc[j] <= crc16_step(crc[j], sd_dat_in[j]);
               word_acc <= word_nxt;
               nib_cnt  <= nib_cnt + 1'b1;
               if (nib_cnt[2:0] == 3'd7) wr_ptr <= wr_ptr + 1'b1;
            end
            // Received CRC bits are checked MSB-first against the shifted
            // local remainder.
            CRC: begin
               if (sd_dat_in != crc_msb) crc_err <= 1'b1;
               for (int j = 0; j < 4; j++)
                  crc[j] <= {crc[j][14:0], 1'b0};
               nib_cnt <= nib_cnt + 1'b1;
            end
            ENDBIT: begin
               if (sd_dat_in != 4'hF) end_err <= 1'b1;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= word_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
         buf_ptr  <= '0;
         irq_en   <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= writedata[2];
         if (wr_ptrreg)
            buf_ptr <= writedata[PW-1:0];
         else if (rd_data)
            buf_ptr <= buf_ptr + 1'b1;
         if (chipselect && read) begin
            unique case (address)
               2'd0: readdata <= {29'b0, irq_en, 2'b0};
               2'd1: readdata <= 32'({wr_ptr, end_err, timeout,
                                      crc_err, done, busy});
               2'd2: readdata <= 32'(buf_ptr);
               2'd3: readdata <= mem[buf_ptr];
               default: readdata <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_dat_block_reader.sv
// Directed/randomised bench for sd_dat_block_reader with a card model and
// a long-division CRC16 reference.
module tb_sd_dat_block_reader;

   localparam int CLK_DIV = 2;
   localparam int TOUT    = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  sd_dat_in;
   logic        sd_clk;
   logic        irq;

   int checks = 0;
   int errors = 0;
   bit stuck  = 0;

   byte unsigned data_b [512];
   logic [31:0]  exp_buf [128];
   logic [3:0]   stream [$];
   logic [31:0]  rd;

   sd_dat_block_reader #(
      .CLK_DIV(CLK_DIV), .TIMEOUT_EDGES(TOUT), .BLOCK_WORDS(128)
   ) dut (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .read(read), .write_n(write_n),
      .writedata(writedata), .readdata(readdata),
      .sd_dat_in(sd_dat_in), .sd_clk(sd_clk), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
   function automatic logic [15:0] crc_line(int j);
      bit msg [1040];
      logic [16:0] gp = 17'h11021;
      logic [15:0] r;
      byte unsigned b;
      for (int n = 0; n < 1040; n++) msg[n] = 1'b0;
      for (int n = 0; n < 1024; n++) begin
         b = data_b[n/2];
         msg[n] = (n % 2 == 0) ? b[4+j] : b[j];
      end
      for (int i = 0; i < 1024; i++)
         if (msg[i])
            for (int t = 0; t <= 16; t++) msg[i+t] ^= gp[16-t];
      for (int t = 0; t < 16; t++) r[15-t] = msg[1024+t];
      return r;
   endfunction

   task automatic build_stream(bit corrupt, logic [3:0] endnib);
      logic [15:0] c [4];
      logic [3:0]  nib;
      byte unsigned b;
      for (int k = 0; k < 128; k++)
         exp_buf[k] = {data_b[4*k+3], data_b[4*k+2],
                       data_b[4*k+1], data_b[4*k]};
      for (int j = 0; j < 4; j++) c[j] = crc_line(j);
      stream.delete();
      repeat (3) stream.push_back(4'hF);
      stream.push_back(4'h0);
      for (int n = 0; n < 1024; n++) begin
         b = data_b[n/2];
         nib = (n % 2 == 0) ? b[7:4] : b[3:0];
         stream.push_back(nib);
      end
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < 4; j++) nib[j] = c[j][15-k];
         if (corrupt && k == 5) nib[2] = ~nib[2];
         stream.push_back(nib);
      end
      stream.push_back(endnib);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 512; i++) data_b[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_rise();
      logic prev;
      bit   seen = 0;
      prev = sd_clk;
      for (int c = 0; c < 64 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (sd_clk && !prev) seen = 1;
         prev = sd_clk;
      end
      if (!seen) begin
         checks++;
         errors++;
         stuck = 1;
         $error("FAIL rise_wait observed=no_rise expected=rise");
      end
   endtask

   task automatic drive(int n);
      for (int i = 0; i < n; i++) begin
         if (stuck || stream.size() == 0) return;
         sd_dat_in = stream.pop_front();
         wait_rise();
      end
   endtask

   task automatic bus_write(logic [1:0] a, logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      @(negedge clk);
      d          = readdata;
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic check_buf(string tag);
      logic [31:0] d;
      bus_write(2'd2, 32'd0);
      for (int i = 0; i < 128; i++) begin
         bus_read(2'd3, d);
         check($sformatf("%s_buf%0d", tag, i), d, exp_buf[i]);
      end
   endtask

   task automatic run_block(bit corrupt, logic [3:0] endnib,
                            logic [31:0] ctrl);
      build_stream(corrupt, endnib);
      sd_dat_in = 4'hF;
      bus_write(2'd0, ctrl | 32'h1);
      drive(stream.size());
   endtask

   initial begin
      logic hi;
      reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0;
      write_n = 1'b1; writedata = '0; sd_dat_in = 4'hF;
      repeat (3) @(negedge clk);
      check("rst_readdata", readdata, 32'd0);
      check("rst_sdclk", 32'(sd_clk), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      bus_read(2'd1, rd); check("rst_status", rd, 32'd0);
      bus_read(2'd0, rd); check("rst_control", rd, 32'd0);
      bus_read(2'd2, rd); check("rst_bufptr", rd, 32'd0);

      for (int i = 0; i < 512; i++) data_b[i] = 8'(i % 256);
      run_block(0, 4'hF, 32'd0);
      bus_read(2'd1, rd); check("clean_status", rd, 32'h2);
      bus_write(2'd2, 32'd0);
      bus_read(2'd3, rd); check("clean_buf0", rd, 32'h03020100);
      bus_write(2'd2, 32'd63);
      bus_read(2'd3, rd); check("clean_buf63", rd, 32'hFFFEFDFC);
      check_buf("clean");

      fill_random();
      run_block(1, 4'hF, 32'd0);
      bus_read(2'd1, rd); check("crcerr_status", rd, 32'h6);
      check_buf("crcerr");

      fill_random();
      run_block(0, 4'hE, 32'd0);
      bus_read(2'd1, rd); check("enderr_status", rd, 32'h12);

      stream.delete();
      repeat (TOUT) stream.push_back(4'hF);
      bus_write(2'd0, 32'h1);
      drive(TOUT - 1);
      bus_read(2'd1, rd); check("tout_before", rd, 32'h1);
      drive(1);
      bus_read(2'd1, rd); check("tout_status", rd, 32'hA);
      hi = 1'b0;
      repeat (20) begin @(negedge clk); hi |= sd_clk; end
      check("tout_sdclk_low", 32'(hi), 32'd0);

      fill_random();
      build_stream(0, 4'hF);
      bus_write(2'd0, 32'h1);
      drive(104);
      bus_write(2'd0, 32'h2);
      check("abort_sdclk", 32'(sd_clk), 32'd0);
      bus_read(2'd1, rd); check("abort_flags", rd & 32'h1F, 32'd0);
      hi = 1'b0;
      repeat (10) begin @(negedge clk); hi |= sd_clk; end
      check("abort_sdclk_idle", 32'(hi), 32'd0);
      fill_random();
      run_block(0, 4'hF, 32'd0);
      bus_read(2'd1, rd); check("post_abort_status", rd, 32'h2);
      check_buf("post_abort");

      bus_write(2'd2, 32'd127);
      bus_read(2'd2, rd); check("bufptr_127", rd, 32'd127);
      bus_read(2'd3, rd); check("bufdata_127", rd, exp_buf[127]);
      bus_read(2'd3, rd); check("bufdata_wrap0", rd, exp_buf[0]);
      bus_read(2'd2, rd); check("bufptr_after", rd, 32'd1);

      bus_write(2'd0, 32'h3);
      bus_read(2'd1, rd); check("startabort_busy", rd & 32'h1, 32'd0);
      hi = 1'b0;
      repeat (10) begin @(negedge clk); hi |= sd_clk; end
      check("startabort_sdclk", 32'(hi), 32'd0);

      fill_random();
      build_stream(0, 4'hF);
      bus_write(2'd0, 32'h5);
      drive(50);
      check("irq_busy", 32'(irq), 32'd0);
      drive(stream.size());
      @(negedge clk);
      check("irq_done", 32'(irq), 32'd1);
      bus_read(2'd0, rd); check("ctrl_irqen", rd, 32'h4);
      bus_read(2'd1, rd); check("irq_status", rd, 32'h2);
      bus_write(2'd0, 32'h0);
      check("irq_off", 32'(irq), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
